// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-requester ROM arbiter: requester select,
// default geometry and the out-of-range address test.
package rom_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int BUS_W      = 32;

    typedef enum logic {
        SEL_IF  = 1'b0,
        SEL_DBG = 1'b1
    } sel_e;

    // True when any address bit at or above addr_w is set.
    function automatic logic addr_oob(input logic [BUS_W-1:0] addr, input int addr_w);
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input round-robin grant logic with the LAST pointer; grants are
// combinational from the requests and suppressed while rst is high.
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_dbg,
    output logic gnt_if,
    output logic gnt_dbg
);

    sel_e       last;
    logic [1:0] starve_if;
    logic [1:0] starve_dbg;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_if  = 1'b0;
        gnt_dbg = 1'b0;
        if (!rst) begin
            if (req_if && req_dbg) begin
                if (last == SEL_DBG) gnt_if  = 1'b1;
                else                 gnt_dbg = 1'b1;
            end else begin
                gnt_if  = req_if;
                gnt_dbg = req_dbg;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= SEL_DBG;
        end else if (gnt_if) begin
            last <= SEL_IF;
        end else if (gnt_dbg) begin
            last <= SEL_DBG;
        end
    end

    // Consecutive cycles a side waits while requesting; saturates at 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_if  <= '0;
            starve_dbg <= '0;
        end else begin
            if (req_if && !gnt_if) starve_if <= (starve_if == 2'd3) ? starve_if : starve_if + 2'd1;
            else                   starve_if <= '0;
            if (req_dbg && !gnt_dbg) starve_dbg <= (starve_dbg == 2'd3) ? starve_dbg : starve_dbg + 2'd1;
            else                     starve_dbg <= '0;
        end
    end

    a_one_grant : assert property (@(posedge clk) disable iff (rst) !(gnt_if && gnt_dbg));
    a_no_starve : assert property (@(posedge clk) disable iff (rst)
                                   (starve_if <= 2'd1) && (starve_dbg <= 2'd1));

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM between the fetch and debug requesters;
// one-cycle read latency, out-of-range indices answer with RERR and zero data.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              IF_REQ,
    input  logic [BUS_W-1:0]  IF_ADDR,
    output logic              IF_GNT,
    output logic              IF_RVALID,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_RERR,

    input  logic              DBG_REQ,
    input  logic [BUS_W-1:0]  DBG_ADDR,
    output logic              DBG_GNT,
    output logic              DBG_RVALID,
    output logic [DATA_W-1:0] DBG_RDATA,
    output logic              DBG_RERR,

    output logic [BUS_W-1:0]  ROM_ADDRESS,
    input  logic [DATA_W-1:0] ROM_RD
);

    logic              gnt_if;
    logic              gnt_dbg;
    logic              gnt_any;
    logic [BUS_W-1:0]  sel_addr;
    logic [BUS_W-1:0]  addr_q;
    logic              addr_err;
    logic [DATA_W-1:0] rd_masked;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req_if  (IF_REQ),
        .req_dbg (DBG_REQ),
        .gnt_if  (gnt_if),
        .gnt_dbg (gnt_dbg)
    );

    assign IF_GNT  = gnt_if;
    assign DBG_GNT = gnt_dbg;
    assign gnt_any = gnt_if | gnt_dbg;

    assign sel_addr    = gnt_dbg ? DBG_ADDR : IF_ADDR;
    // Without a grant the ROM keeps seeing the last granted index.
    assign ROM_ADDRESS = gnt_any ? sel_addr : addr_q;
    assign addr_err    = addr_oob(sel_addr, ADDR_W);
    assign rd_masked   = addr_err ? '0 : ROM_RD;

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q     <= '0;
            IF_RVALID  <= 1'b0;
            IF_RERR    <= 1'b0;
            IF_RDATA   <= '0;
            DBG_RVALID <= 1'b0;
            DBG_RERR   <= 1'b0;
            DBG_RDATA  <= '0;
        end else begin
            if (gnt_any) addr_q <= sel_addr;

            IF_RVALID  <= gnt_if;
            IF_RERR    <= gnt_if & addr_err;
            if (gnt_if) IF_RDATA <= rd_masked;

            DBG_RVALID <= gnt_dbg;
            DBG_RERR   <= gnt_dbg & addr_err;
            if (gnt_dbg) DBG_RDATA <= rd_masked;
        end
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the number of ROM word-index bits (256 words).
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port IF_REQ  input  1  SHALL be the fetch-side read request.
REQ-006 Port IF_ADDR  input  32  SHALL be the fetch-side word index.
REQ-007 Port IF_GNT  output  1  SHALL indicate that the fetch request is accepted this cycle.
REQ-008 Port IF_RVALID  output  1  SHALL pulse when IF_RDATA/IF_RERR are valid.
REQ-009 Port IF_RDATA  output  DATA_W  SHALL carry the fetch-side read data.
REQ-010 Port IF_RERR  output  1  SHALL flag an out-of-range fetch address.
REQ-011 Ports DBG_REQ, DBG_ADDR, DBG_GNT, DBG_RVALID, DBG_RDATA, DBG_RERR SHALL mirror REQ-005..010 for the debug/loader requester.
REQ-012 Port ROM_ADDRESS  output  32  SHALL drive the ROM word index.
REQ-013 Port ROM_RD  input  DATA_W  SHALL receive combinational ROM read data.

Function
REQ-014 At most one of IF_GNT, DBG_GNT SHALL be high in any cycle; grants SHALL be combinational from REQ inputs and arbiter state.
REQ-015 Only one requester asserting REQ SHALL receive the grant in the same cycle.
REQ-016 If both assert REQ, the grant SHALL go to the requester not recorded in the LAST pointer (round-robin).
REQ-017 LAST SHALL update to the granted requester at each edge where a grant occurs; with no grant, LAST SHALL hold.
REQ-018 ROM_ADDRESS SHALL equal the granted requester's address; with no grant, it SHALL hold the last driven value (registered copy).
REQ-019 On the edge ending a grant cycle, the granted side's RDATA SHALL register ROM_RD and its RVALID SHALL be high for exactly the following cycle (latency 1).
REQ-020 An address with any bit at or above ADDR_W set SHALL still be granted, but the response SHALL have RERR=1 and RDATA=0.
REQ-021 RDATA SHALL hold its value between responses; RVALID and RERR SHALL be 0 when no response is issued.
REQ-022 A requester SHALL hold REQ and ADDR stable until GNT; REQ deasserted before GNT SHALL be treated as withdrawn with no response.
REQ-023 Back-to-back grants to the same requester SHALL be allowed when the other is not requesting (one response per cycle).
REQ-024 A starvation counter SHALL count consecutive cycles a requesting side is not granted; it SHALL never exceed 1 under REQ-016 and SHALL be exposed only for assertions.

Reset
REQ-025 While RST is high at an edge: LAST SHALL become DBG (so IF wins the first tie), all RVALID/RERR 0, all RDATA 0, held ROM_ADDRESS 0.
REQ-026 Grants SHALL be suppressed (0) while RST is high; a grant cycle coinciding with reset SHALL produce no response.

Structure
REQ-027 A shared package SHALL hold the requester-select enum (SEL_IF, SEL_DBG) and the default ADDR_W/DATA_W constants.
REQ-028 One sub-module, rr_arb2, SHALL implement the two-input round-robin grant logic and the LAST pointer.

Verification
REQ-029 IF_REQ=1, IF_ADDR=5, DBG_REQ=0, ROM[5]=0x2010000A -> IF_GNT=1 in cycle 0, IF_RVALID=1 with IF_RDATA=0x2010000A in cycle 1.
REQ-030 Both requesting for 4 cycles after reset (IF_ADDR=1, DBG_ADDR=2) -> grants IF, DBG, IF, DBG; responses alternate with ROM[1]/ROM[2].
REQ-031 DBG_REQ=1, DBG_ADDR=0x100 -> DBG_GNT=1, next cycle DBG_RVALID=1, DBG_RERR=1, DBG_RDATA=0.
REQ-032 RST asserted in a grant cycle (IF_ADDR=3) -> next cycle IF_RVALID=0, IF_RDATA=0; first tie after reset grants IF.
REQ-033 IF_REQ held 3 cycles alone (addr 7,8,9) -> three consecutive grants and RVALID pulses with ROM[7..9]; random-stimulus assertions confirm REQ-014 and REQ-024.
